// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding, S-box table,
// round-constant lookup and the ShiftRows / MixColumns helpers.
// Byte order everywhere: [127:120] is byte 0, columns are consecutive 32-bit words.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Forward S-box, index 0 is the leftmost byte of the constant.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = col;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of AES-128 key expansion: current round key in, next round key out.
module aes_key_step (
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon_byte,
  output logic [127:0] rkey_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3;
  logic [31:0] w4, w5, w6, w7;

  assign {w0, w1, w2, w3} = rkey;

  // RotWord: {a,b,c,d} -> {b,c,d,a}
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .value(rot_w3[8*g +: 8]),
      .subst(sub_w3[8*g +: 8])
    );
  end

  assign w4 = w0 ^ sub_w3 ^ {rcon_byte, 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign rkey_next = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_sbox.sv
// Single forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  assign subst = SBOX_TABLE[value];

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes over the full 128-bit state: sixteen parallel S-boxes.
module aes_sub_bytes (
  input  logic [127:0] state,
  output logic [127:0] state_sub
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .value(state[8*g +: 8]),
      .subst(state_sub[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, key expanded on the fly.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// ciphertext stays stable until the sink takes it. Inputs are sampled only on
// the accepting edge; valid/ready outside their owning state are ignored.
module aes128_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_fsm_e     fsm;
  logic [127:0] state_reg;
  logic [127:0] rkey_reg;
  logic [3:0]   rnd;

  logic [127:0] sub_state;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic [7:0]   rcon_byte;

  aes_sub_bytes u_sub_bytes (
    .state    (state_reg),
    .state_sub(sub_state)
  );

  assign rcon_byte = rcon(rnd);

  aes_key_step u_key_step (
    .rkey     (rkey_reg),
    .rcon_byte(rcon_byte),
    .rkey_next(rk_next)
  );

  // The last round skips MixColumns.
  assign shifted   = shift_rows(sub_state);
  assign mixed     = mix_columns(shifted);
  assign round_out = ((rnd == LAST_RND) ? shifted : mixed) ^ rk_next;

  // Control FSM plus state/key/counter registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
      state_reg  <= '0;
      rkey_reg   <= '0;
      rnd        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= plaintext ^ key;
            rkey_reg  <= key;
            rnd       <= 4'd1;
            in_ready  <= 1'b0;
            fsm       <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          rkey_reg  <= rk_next;
          rnd       <= rnd + 4'd1;
          if (rnd == LAST_RND) begin
            ciphertext <= round_out;
            out_valid  <= 1'b1;
            fsm        <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption core: one round per clock, with on-the-fly key expansion.
- Holds the 128-bit round-state register that feeds the existing SubBytes block. ShiftRows, MixColumns and AddRoundKey follow SubBytes combinationally, and the result loops back into the register.
- Valid/ready handshake on both input and output.
- Sits between the host block loader and the ciphertext sink.

Parameters:
- None. AES-128 only. NR=10 is a fixed package constant.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key pair offered
- in_ready  out  1  core can accept a block
- plaintext  in  128  input block; [127:120] = FIPS byte 0, column-major
- key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  sink accepts ciphertext
- ciphertext  out  128  result, same byte order

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE. out_valid=0. ciphertext=0. Internal state, round-key and round-counter registers are all 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - state_reg <= plaintext ^ key
  - rkey_reg <= key
  - rnd <= 1
  - go to ROUND
  - plaintext and key are sampled only at this edge; later changes are ignored.
- ROUND: in_ready=0. Each cycle:
  - rk_next = key_step(rkey_reg, rcon[rnd])
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk_next)
  - MixColumns is bypassed when rnd==10
  - rkey_reg <= rk_next; rnd <= rnd+1
  - At rnd==10 the result is also loaded into ciphertext, out_valid <= 1, go to DONE.
- Latency: out_valid rises exactly 10 clocks after the accepting edge.
- DONE: out_valid=1, ciphertext held stable.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE; in_ready=1 on the next cycle.
  - No new block is accepted in the same cycle as the output handshake. Minimum period is 12 cycles per block with out_ready tied high.
- Backpressure: the core may stay in DONE indefinitely; outputs do not change.
- rcon: 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
- key_step: w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6. w0 = rkey[127:96].
- MixColumns: GF(2^8) with xtime, reduction polynomial 0x11b.
- in_valid while not IDLE: ignored; the input is not captured.
- rst_n asserted mid-operation: immediate asynchronous return to reset values; the partial block is discarded.
- out_ready while not DONE: ignored.

Decomposition:
- aes_pkg:
  - NR=10
  - rcon table (function indexed 1..10)
  - FSM enum {IDLE, ROUND, DONE}
  - xtime and mix_column functions
- Sub-module aes_key_step: 128-bit round key in, 8-bit rcon in, next round key out. Contains 4 sbox instances for SubWord.
- Data path instantiates the existing SubBytes module for the state. ShiftRows and MixColumns stay inline as package functions.

Test Plan:
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 → ciphertext 3925841d02dc09fbdc118597196a0b32 exactly 10 cycles after accept. Internal state after round 1 = a49c7ff2689f352b6b5bea43026a5049. Final round key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App.C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_valid stays 1, ciphertext stable, in_ready=0. Raise out_ready → one-cycle handshake, then in_ready=1.
- Input changes during ROUND: change key/plaintext and pulse in_valid every cycle → result still equals the App.B ciphertext; no second block is accepted.
- Back-to-back: in_valid held high with App.B then App.C.1 vectors, out_ready=1 → two correct ciphertexts, accepts 12 cycles apart.
- Reset mid-operation: drop rst_n at round 5 → out_valid=0, ciphertext=0 immediately. After release, in_ready=1 and a fresh App.C.1 block produces the correct result.
